// File: rtl/width_combin_arbiter.sv
// width_combin_arbiter: packet-locked round-robin arbiter sharing one width_combin between NCH channels.
// Define WIDTH_COMBIN_ARB_PRIO0_EN to give channel 0 strict priority at arbitration.
module width_combin_arbiter #(
  parameter int DSIZE = 1,
  parameter int NCH = 4,
  parameter int IDDEPTH = 4
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NCH*DSIZE-1:0]    ch_data,
  input  logic [NCH-1:0]          ch_vld,
  input  logic [NCH-1:0]          ch_last,
  input  logic [NCH-1:0]          ch_align_last,
  output logic [NCH-1:0]          ch_ready,
  output logic [DSIZE-1:0]        cb_wr_data,
  output logic                    cb_wr_vld,
  output logic                    cb_wr_last,
  output logic                    cb_wr_align,
  input  logic                    cb_wr_ready,
  input  logic                    cb_rd_vld,
  input  logic                    cb_rd_ready,
  input  logic                    cb_rd_last,
  output logic [$clog2(NCH)-1:0]  out_id,
  output logic                    out_id_vld
);
  localparam int IW = $clog2(NCH);
  localparam int AW = $clog2(IDDEPTH);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [IW-1:0] grant, rr_ptr, winner, grant_inc;
  logic [IW-1:0] ids [IDDEPTH];
  logic [AW:0] wp, rp, cnt;
  logic lock, any_req, full, push, pop, done;
  int idx;
  assign lock = state == LOCK;
  assign cnt = wp - rp;
  assign full = cnt == (AW+1)'(IDDEPTH);
  assign out_id_vld = wp != rp;
  assign out_id = out_id_vld ? ids[rp[AW-1:0]] : '0;
  // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    idx = 0;
    winner = rr_ptr;
    any_req = 1'b0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= NCH ? idx - NCH : idx;
      if (ch_vld[idx]) begin
        winner = IW'(idx);
        any_req = 1'b1;
      end
    end
`ifdef WIDTH_COMBIN_ARB_PRIO0_EN
    winner = ch_vld[0] ? '0 : winner;
`endif
  end
  assign push = !lock && any_req && !full;
  assign pop = cb_rd_vld && cb_rd_ready && cb_rd_last && out_id_vld;
  assign cb_wr_vld = lock && ch_vld[grant];
  assign cb_wr_last = lock && ch_last[grant];
  assign cb_wr_align = lock && ch_align_last[grant];
  assign cb_wr_data = lock ? ch_data[DSIZE*grant +: DSIZE] : '0;
  assign done = cb_wr_vld && cb_wr_ready && cb_wr_last;
  assign grant_inc = grant == IW'(NCH-1) ? '0 : grant + 1'b1;
  always_comb begin
    ch_ready = '0;
    ch_ready[grant] = lock && cb_wr_ready;
  end
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        state <= LOCK;
        grant <= winner;
        ids[wp[AW-1:0]] <= winner;
      end else if (done) begin
        state <= IDLE;
`ifdef WIDTH_COMBIN_ARB_PRIO0_EN
        rr_ptr <= grant == '0 ? rr_ptr : grant_inc;
`else
        rr_ptr <= grant_inc;
`endif
      end
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_width_combin_arbiter.sv
// tb_width_combin_arbiter: scoreboard bench for width_combin_arbiter (NCH=4, DSIZE=8, IDDEPTH=4).
module tb_width_combin_arbiter;
  typedef struct {logic [7:0] d; logic l; logic a;} beat_t;
  typedef struct {int ch; logic [7:0] d; logic l; logic a;} exp_t;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] ch_data;
  logic [3:0] ch_vld, ch_last, ch_align_last, ch_ready, acc;
  logic [7:0] cb_wr_data;
  logic cb_wr_vld, cb_wr_last, cb_wr_align;
  logic cb_wr_ready = 1'b1;
  logic cb_rd_vld = 1'b0, cb_rd_ready = 1'b0, cb_rd_last = 1'b0;
  logic [1:0] out_id;
  logic out_id_vld;
  logic hold [4];
  beat_t src [4][$];
  exp_t exp_q [$];
  int exp_id [$];
  int cyc_q [$];
  int n_cmp = 0, n_bad = 0, cyc = 0;

  width_combin_arbiter #(.DSIZE(8), .NCH(4), .IDDEPTH(4)) dut (
    .clock(clock), .rst_n(rst_n), .ch_data(ch_data), .ch_vld(ch_vld), .ch_last(ch_last),
    .ch_align_last(ch_align_last), .ch_ready(ch_ready), .cb_wr_data(cb_wr_data),
    .cb_wr_vld(cb_wr_vld), .cb_wr_last(cb_wr_last), .cb_wr_align(cb_wr_align),
    .cb_wr_ready(cb_wr_ready), .cb_rd_vld(cb_rd_vld), .cb_rd_ready(cb_rd_ready),
    .cb_rd_last(cb_rd_last), .out_id(out_id), .out_id_vld(out_id_vld)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void refresh();
    for (int i = 0; i < 4; i++) begin
      ch_vld[i] = src[i].size() > 0 && !hold[i];
      ch_data[8*i +: 8] = src[i].size() > 0 ? src[i][0].d : 8'h00;
      ch_last[i] = src[i].size() > 0 ? src[i][0].l : 1'b0;
      ch_align_last[i] = src[i].size() > 0 ? src[i][0].a : 1'b0;
    end
  endfunction

  // Inputs change only here, on the falling edge; a beat seen here is taken at the next rising edge.
  always @(negedge clock) begin : mon
    exp_t e;
    for (int i = 0; i < 4; i++)
      if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
    refresh();
    #1;
    cyc++;
    if (cb_wr_vld && cb_wr_ready) begin
      cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_unexpected: got %02h, none required", cb_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'(cb_wr_data), 32'(e.d));
        check("beat_last", 32'(cb_wr_last), 32'(e.l));
        check("beat_align", 32'(cb_wr_align), 32'(e.a));
        check("beat_ready", 32'(ch_ready), 32'(1 << e.ch));
      end
    end
    if (cb_rd_vld && cb_rd_ready && cb_rd_last && out_id_vld) begin
      if (exp_id.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL id_unexpected: got %0d, none required", out_id);
      end else check("out_id", 32'(out_id), 32'(exp_id.pop_front()));
    end
    for (int i = 0; i < 4; i++) acc[i] = ch_vld[i] && ch_ready[i];
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_rd(logic v);
    cb_rd_vld = v;
    cb_rd_ready = v;
    cb_rd_last = v;
  endtask

  task automatic send(int ch, int n, logic [7:0] base);
    for (int k = 0; k < n; k++)
      src[ch].push_back(beat_t'{d: 8'(base + 8'(k)), l: k == n-1, a: k == n-1 && ch[0]});
  endtask

  task automatic expect_pkt(int ch, int n, logic [7:0] base);
    for (int k = 0; k < n; k++)
      exp_q.push_back(exp_t'{ch: ch, d: 8'(base + 8'(k)), l: k == n-1, a: k == n-1 && ch[0]});
    exp_id.push_back(ch);
  endtask

  task automatic wait_beats(string name, int left);
    int n = 0;
    while (exp_q.size() > left && n < 100) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'(left));
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((exp_q.size() > 0 || exp_id.size() > 0) && n < 200) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size() + exp_id.size()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_rd(1'b0);
    cb_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src[i].delete();
      hold[i] = 1'b0;
    end
    acc = '0;
    exp_q.delete();
    exp_id.delete();
    step(2);
    rst_n = 1'b1;
    check("rst_ch_ready", 32'(ch_ready), 0);
    check("rst_wr_vld", 32'(cb_wr_vld), 0);
    check("rst_wr_last", 32'(cb_wr_last), 0);
    check("rst_wr_align", 32'(cb_wr_align), 0);
    check("rst_wr_data", 32'(cb_wr_data), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_out_id_vld", 32'(out_id_vld), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // single 4-beat packet on ch1 with one cycle of combiner back-pressure
    send(1, 4, 8'h11);
    expect_pkt(1, 4, 8'h11);
    step();
    check("t1_ready", 32'(ch_ready), 32'h2);
    check("t1_id_vld", 32'(out_id_vld), 1);
    check("t1_id", 32'(out_id), 1);
    cb_wr_ready = 1'b0;
    #1;
    check("t1_stall_ready", 32'(ch_ready), 0);
    check("t1_stall_vld", 32'(cb_wr_vld), 1);
    step();
    cb_wr_ready = 1'b1;
    wait_beats("t1_beats", 0);
    step();
    check("t1_idle_ready", 32'(ch_ready), 0);
    check("t1_hold_id_vld", 32'(out_id_vld), 1);
    check("t1_hold_id", 32'(out_id), 1);
    set_rd(1'b1);
    step();
    set_rd(1'b0);
    check("t1_pop_id_vld", 32'(out_id_vld), 0);
    // every channel requests, 2-beat packets, ch0 has two packets
    do_reset();
    set_rd(1'b1);
    cyc_q.delete();
    send(0, 2, 8'h01);
    send(0, 2, 8'h03);
    send(1, 2, 8'h21);
    send(2, 2, 8'h31);
    send(3, 2, 8'h41);
    expect_pkt(0, 2, 8'h01);
`ifdef WIDTH_COMBIN_ARB_PRIO0_EN
    expect_pkt(0, 2, 8'h03);
`endif
    expect_pkt(1, 2, 8'h21);
    expect_pkt(2, 2, 8'h31);
    expect_pkt(3, 2, 8'h41);
`ifndef WIDTH_COMBIN_ARB_PRIO0_EN
    expect_pkt(0, 2, 8'h03);
`endif
    drain("t2_drain");
    check("t2_beat_count", 32'(cyc_q.size()), 10);
    for (int i = 1; i < 10 && i < cyc_q.size(); i++)
      check("t2_bubble", 32'(cyc_q[i] - cyc_q[0]), 32'(i + i/2));
    // ch2 stalls mid-packet while ch3 waits
    send(2, 3, 8'h51);
    send(3, 2, 8'h61);
    expect_pkt(2, 3, 8'h51);
    expect_pkt(3, 2, 8'h61);
    step(2);
    hold[2] = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_ready", 32'(ch_ready), 32'h4);
      check("t3_stall_vld", 32'(cb_wr_vld), 0);
      if (i < 2) step();
    end
    hold[2] = 1'b0;
    drain("t3_drain");
    // ID FIFO full blocks the fifth grant until one output packet retires
    set_rd(1'b0);
    send(0, 1, 8'h80);
    send(1, 1, 8'h90);
    send(2, 1, 8'hA0);
    send(3, 1, 8'hB0);
    send(1, 1, 8'h91);
    expect_pkt(0, 1, 8'h80);
    expect_pkt(1, 1, 8'h90);
    expect_pkt(2, 1, 8'hA0);
    expect_pkt(3, 1, 8'hB0);
    expect_pkt(1, 1, 8'h91);
    wait_beats("t4_four", 1);
    step(3);
    check("t4_blocked", 32'(exp_q.size()), 1);
    check("t4_blocked_ready", 32'(ch_ready), 0);
    check("t4_blocked_vld", 32'(cb_wr_vld), 0);
    check("t4_full_id_vld", 32'(out_id_vld), 1);
    check("t4_full_id", 32'(out_id), 0);
    set_rd(1'b1);
    step();
    set_rd(1'b0);
    step();
    check("t4_regrant", 32'(ch_ready), 32'h2);
    set_rd(1'b1);
    drain("t4_drain");
    // reset while ch1 beat 2 is on the bus
    set_rd(1'b0);
    send(1, 4, 8'h71);
    exp_q.push_back(exp_t'{ch: 1, d: 8'h71, l: 1'b0, a: 1'b0});
    exp_q.push_back(exp_t'{ch: 1, d: 8'h72, l: 1'b0, a: 1'b0});
    expect_pkt(1, 2, 8'h73);
    step();
    check("t5_id_vld", 32'(out_id_vld), 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_ready", 32'(ch_ready), 0);
    check("t5_rst_vld", 32'(cb_wr_vld), 0);
    check("t5_rst_id_vld", 32'(out_id_vld), 0);
    set_rd(1'b1);
    drain("t5_drain");
    // ch0 and ch3 contend repeatedly
    do_reset();
    set_rd(1'b1);
    send(0, 1, 8'hC0);
    send(0, 1, 8'hC1);
    send(3, 1, 8'hD0);
    send(3, 1, 8'hD1);
    expect_pkt(0, 1, 8'hC0);
`ifdef WIDTH_COMBIN_ARB_PRIO0_EN
    expect_pkt(0, 1, 8'hC1);
    expect_pkt(3, 1, 8'hD0);
`else
    expect_pkt(3, 1, 8'hD0);
    expect_pkt(0, 1, 8'hC1);
`endif
    expect_pkt(3, 1, 8'hD1);
    drain("t6_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
